// File: rtl/formant_pkg.sv
// Shared types, constants and arithmetic helpers for the formant blocks.
package formant_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } synth_state_t;

    localparam int unsigned I_DEFAULT  = 160;
    localparam int unsigned I_WIDTH    = $clog2(I_DEFAULT);
    localparam int unsigned PIPE_DEPTH = 3;

    // Unsigned add clamped to the largest value representable in `width` bits.
    // Both operands are expected to already be within that range (width <= 63).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [63:0] lim;
        logic [63:0] sum;
        lim = (64'd1 << width) - 64'd1;
        sum = a + b;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/formant_spectrum_synth_if.sv
// Frame-in / spectrum-stream-out bundle of the formant spectrum synthesiser.
interface formant_spectrum_synth_if
    import formant_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned FORMANTS  = 5,
    parameter int unsigned IDX_W     = I_WIDTH
);

    logic                                formant_valid;
    logic [0:FORMANTS-1][BIT_WIDTH-1:0] formant_freq;
    logic                                busy;
    logic                                spec_valid;
    logic [BIT_WIDTH-1:0]                spec_data;
    logic [IDX_W-1:0]                    spec_index;
    logic                                spec_last;
    logic                                overrun;

    modport master (
        output formant_valid, formant_freq,
        input  busy, spec_valid, spec_data, spec_index, spec_last, overrun
    );

    modport slave (
        input  formant_valid, formant_freq,
        output busy, spec_valid, spec_data, spec_index, spec_last, overrun
    );

endinterface

// File: rtl/formant_tri_contrib.sv
// Two-stage triangular resonance of one formant: bin distance, then clipped contribution.
module formant_tri_contrib
    import formant_pkg::*;
#(
    parameter int unsigned     BIT_WIDTH = 32,
    parameter int unsigned     IDX_W     = I_WIDTH,
    parameter int unsigned     FRAC_BITS = 8,
    parameter longint unsigned PEAK      = 64'd65536,
    parameter longint unsigned SLOPE     = 64'd4096
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [IDX_W-1:0]     bin,
    input  logic [BIT_WIDTH-1:0] freq,
    output logic [BIT_WIDTH-1:0] contrib
);

    localparam int unsigned PW = 2 * BIT_WIDTH;

    logic [BIT_WIDTH-1:0] pos;
    logic [BIT_WIDTH-1:0] dist_d, dist_q;
    logic                 off_d, off_q;
    logic [PW-1:0]        prod, pen, peak_w;
    logic [BIT_WIDTH-1:0] contrib_d, contrib_q;

    // S1: absolute distance between the bin centre and the formant, fixed point.
    always_comb begin
        pos    = BIT_WIDTH'(bin) << FRAC_BITS;
        dist_d = (pos >= freq) ? (pos - freq) : (freq - pos);
        off_d  = (freq == '0);
    end

    // S2: linear decay from PEAK, clipped at zero; disabled formants give nothing.
    always_comb begin
        peak_w    = PW'(PEAK);
        prod      = PW'(dist_q) * PW'(SLOPE);
        pen       = prod >> FRAC_BITS;
        contrib_d = (off_q || (pen >= peak_w)) ? '0 : BIT_WIDTH'(peak_w - pen);
    end

    // Stage registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dist_q    <= '0;
            off_q     <= 1'b1;
            contrib_q <= '0;
        end else begin
            dist_q    <= dist_d;
            off_q     <= off_d;
            contrib_q <= contrib_d;
        end
    end

    assign contrib = contrib_q;

endmodule

// File: rtl/formant_spectrum_synth.sv
// Regenerates a triangular-resonance magnitude envelope, one bin per cycle, from a formant frame.
module formant_spectrum_synth
    import formant_pkg::*;
#(
    parameter int unsigned     BIT_WIDTH = 32,
    parameter int unsigned     I         = I_DEFAULT,
    parameter int unsigned     FORMANTS  = 5,
    parameter int unsigned     FRAC_BITS = 8,
    parameter longint unsigned PEAK      = 64'd65536,
    parameter longint unsigned SLOPE     = 64'd4096
) (
    input logic                    clk_in,
    input logic                    rst_in,
    formant_spectrum_synth_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(I);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(I - 1);

    typedef logic [0:FORMANTS-1][BIT_WIDTH-1:0] frame_t;

    synth_state_t            state_d, state_q;
    logic [IDX_W-1:0]        cnt_d, cnt_q;
    frame_t                  active_d, active_q;
    frame_t                  pend_d, pend_q;
    logic                    pend_full_d, pend_full_q;
    logic                    overrun_d, overrun_q;
    logic [PIPE_DEPTH-1:0]   vld_d, vld_q;
    logic [PIPE_DEPTH-1:0]   last_d, last_q;
    logic [IDX_W-1:0]        idx_d [PIPE_DEPTH];
    logic [IDX_W-1:0]        idx_q [PIPE_DEPTH];
    logic [BIT_WIDTH-1:0]    data_d, data_q;
    logic [BIT_WIDTH-1:0]    contrib [FORMANTS];
    logic [63:0]             acc;
    logic                    boundary;
    logic                    run;

    for (genvar k = 0; k < FORMANTS; k++) begin : g_tri
        formant_tri_contrib #(
            .BIT_WIDTH (BIT_WIDTH),
            .IDX_W     (IDX_W),
            .FRAC_BITS (FRAC_BITS),
            .PEAK      (PEAK),
            .SLOPE     (SLOPE)
        ) u_tri (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .bin     (cnt_q),
            .freq    (active_q[k]),
            .contrib (contrib[k])
        );
    end

    // Frame sequencing: capture, bin counting, pending slot and back-to-back restart.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = 1'b0;
        boundary    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.formant_valid) begin
                    active_d = bus.formant_freq;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN, DRAIN: begin
                // A new frame may only start once the last bin has been issued; a strobe on
                // that same cycle is newer than the pending slot and displaces it.
                boundary = (state_q == DRAIN) || (cnt_q == LAST_BIN);
                if (boundary && (bus.formant_valid || pend_full_q)) begin
                    active_d    = bus.formant_valid ? bus.formant_freq : pend_q;
                    overrun_d   = bus.formant_valid && pend_full_q;
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RUN;
                end else if (boundary) begin
                    if (state_q == RUN) begin
                        state_d = DRAIN;
                    end else if (vld_q[PIPE_DEPTH-2:0] == '0) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (bus.formant_valid) begin
                        pend_d      = bus.formant_freq;
                        pend_full_d = 1'b1;
                        overrun_d   = pend_full_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Side-band pipeline (valid/index/last) and the S3 saturating adder tree.
    always_comb begin
        run      = (state_q == RUN);
        vld_d    = {vld_q[PIPE_DEPTH-2:0], run};
        last_d   = {last_q[PIPE_DEPTH-2:0], run && (cnt_q == LAST_BIN)};
        idx_d[0] = run ? cnt_q : '0;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            idx_d[i] = idx_q[i-1];
        end
        acc = '0;
        for (int unsigned k = 0; k < FORMANTS; k++) begin
            acc = sat_add(acc, 64'(contrib[k]), BIT_WIDTH);
        end
        data_d = vld_q[PIPE_DEPTH-2] ? BIT_WIDTH'(acc) : '0;
    end

    // State and pipeline registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            vld_q       <= '0;
            last_q      <= '0;
            data_q      <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            data_q      <= data_d;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign bus.busy       = (state_q != IDLE) || (|vld_q);
    assign bus.spec_valid = vld_q[PIPE_DEPTH-1];
    assign bus.spec_data  = data_q;
    assign bus.spec_index = idx_q[PIPE_DEPTH-1];
    assign bus.spec_last  = last_q[PIPE_DEPTH-1];
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_formant_spectrum_synth.sv
// Directed bench for formant_spectrum_synth: per-cycle stream compare against a frame model.
module tb_formant_spectrum_synth;
    import formant_pkg::*;

    localparam int unsigned     NB       = 160;
    localparam longint unsigned SAT_PEAK = 64'h8000_0000;

    typedef logic [0:4][31:0] frame_t;
    typedef struct {
        int unsigned idx;
        logic [31:0] data;
        logic        last;
    } bin_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    formant_spectrum_synth_if #(.BIT_WIDTH(32), .FORMANTS(5), .IDX_W(8)) m_if ();
    formant_spectrum_synth_if #(.BIT_WIDTH(32), .FORMANTS(5), .IDX_W(8)) s_if ();

    formant_spectrum_synth #(
        .BIT_WIDTH(32), .I(160), .FORMANTS(5), .FRAC_BITS(8),
        .PEAK(64'd65536), .SLOPE(64'd4096)
    ) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (m_if.slave)
    );

    formant_spectrum_synth #(
        .BIT_WIDTH(32), .I(160), .FORMANTS(5), .FRAC_BITS(8),
        .PEAK(SAT_PEAK), .SLOPE(64'd1)
    ) u_sat (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (s_if.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          ncyc = 0;
    int          sc = 0;
    int          last_start = 0;
    int          last_last = 0;
    int          busy_fall = 0;
    int          b2b_gap = 0;
    int          vcount = 0;
    int          ovr_cnt = 0;
    int          sat_vcount = 0;
    logic [31:0] sat_got50 = '0;
    logic [31:0] got [NB];
    bin_t        exp_q [$];
    frame_t      sat_frame = '0;
    logic        prev_valid = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_busy = 1'b0;

    // Envelope value of one bin: sum of clipped triangles, clamped to 32 bits.
    function automatic logic [31:0] model_bin(input frame_t f, input int unsigned b,
                                              input longint unsigned peak,
                                              input longint unsigned slope);
        longint unsigned total, pos, d, pen;
        total = 0;
        pos   = longint'(b) * 256;
        for (int unsigned k = 0; k < 5; k++) begin
            if (f[k] != 0) begin
                d   = (pos > f[k]) ? pos - f[k] : f[k] - pos;
                pen = (d * slope) / 256;
                if (pen < peak) total += peak - pen;
            end
        end
        return (total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : total[31:0];
    endfunction

    task automatic push_frame(input frame_t f);
        bin_t e;
        for (int unsigned b = 0; b < NB; b++) begin
            e.idx  = b;
            e.data = model_bin(f, b, 64'd65536, 64'd4096);
            e.last = (b == NB - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input longint actual, input longint required);
        n_checks++;
        if (actual != required) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic strobe_main(input frame_t f);
        @(negedge clk); #1;
        m_if.formant_valid = 1'b1;
        m_if.formant_freq  = f;
        sc = ncyc;
        @(negedge clk); #1;
        m_if.formant_valid = 1'b0;
        m_if.formant_freq  = '0;
    endtask

    task automatic strobe_sat(input frame_t f);
        @(negedge clk); #1;
        s_if.formant_valid = 1'b1;
        s_if.formant_freq  = f;
        @(negedge clk); #1;
        s_if.formant_valid = 1'b0;
        s_if.formant_freq  = '0;
    endtask

    task automatic wait_main(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((exp_q.size() != 0 || m_if.busy) && n < 1000);
        n_checks++;
        if (n >= 1000) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d bins outstanding after %0d cycles, required 0", name, exp_q.size(), n);
        end
    endtask

    // Per-cycle compare of both DUT streams against the model.
    always @(negedge clk) begin
        bin_t e;
        ncyc++;
        if (!rst) begin
            if (prev_valid && !prev_last) begin
                n_checks++;
                if (!m_if.spec_valid) begin
                    n_errors++;
                    $display("FAIL stream_gap: got spec_valid 0 mid-frame at cycle %0d, required 1", ncyc);
                end
            end
            if (m_if.spec_valid) begin
                vcount++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL stream_extra: got idx %0d data %0d, required no output",
                             m_if.spec_index, m_if.spec_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_if.spec_index !== 8'(e.idx) || m_if.spec_data !== e.data ||
                        m_if.spec_last !== e.last) begin
                        n_errors++;
                        $display("FAIL stream_bin: got idx %0d data %0d last %0b, required idx %0d data %0d last %0b",
                                 m_if.spec_index, m_if.spec_data, m_if.spec_last, e.idx, e.data, e.last);
                    end
                end
                if (m_if.spec_index < NB) got[m_if.spec_index] = m_if.spec_data;
                if (m_if.spec_index == 0) begin
                    last_start = ncyc;
                    b2b_gap    = ncyc - last_last;
                end
                if (m_if.spec_last) last_last = ncyc;
            end
            if (m_if.overrun) ovr_cnt++;
            if (prev_busy && !m_if.busy) busy_fall = ncyc;
            if (s_if.spec_valid) begin
                sat_vcount++;
                n_checks++;
                if (s_if.spec_data !== model_bin(sat_frame, s_if.spec_index, SAT_PEAK, 64'd1)) begin
                    n_errors++;
                    $display("FAIL sat_bin: idx %0d got %0h, required %0h", s_if.spec_index, s_if.spec_data,
                             model_bin(sat_frame, s_if.spec_index, SAT_PEAK, 64'd1));
                end
                if (s_if.spec_index == 50) sat_got50 = s_if.spec_data;
            end
        end
        prev_valid = m_if.spec_valid;
        prev_last  = m_if.spec_last;
        prev_busy  = m_if.busy;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        frame_t f, fa, fb, fc;
        int n;
        m_if.formant_valid = 1'b0;
        m_if.formant_freq  = '0;
        s_if.formant_valid = 1'b0;
        s_if.formant_freq  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_spec_valid", m_if.spec_valid, 0);
        check("rst_spec_data", m_if.spec_data, 0);
        check("rst_spec_index", m_if.spec_index, 0);
        check("rst_spec_last", m_if.spec_last, 0);
        check("rst_busy", m_if.busy, 0);
        check("rst_overrun", m_if.overrun, 0);
        rst = 1'b0;

        // Saturation: five coincident formants with a huge PEAK
        sat_frame = {5{32'd12800}};
        strobe_sat(sat_frame);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (s_if.busy && n < 1000);
        check("sat_done", n < 1000, 1);
        check("sat_bin50", sat_got50, 32'hFFFF_FFFF);
        check("sat_valid_count", sat_vcount, 160);

        // Single formant at bin 10
        f = '0;
        f[0] = 32'd2560;
        push_frame(f);
        vcount = 0;
        strobe_main(f);
        wait_main("single");
        check("single_latency", last_start - sc, 4);
        check("single_valid_count", vcount, 160);
        check("single_bin0", got[0], 24576);
        check("single_bin9", got[9], 61440);
        check("single_bin10", got[10], 65536);
        check("single_bin11", got[11], 61440);
        check("single_bin25", got[25], 4096);
        check("single_bin26", got[26], 0);
        check("single_bin159", got[159], 0);
        check("single_busy_fall", busy_fall - last_last, 1);

        // Overlapping formants at bins 20 and 22
        f = '0;
        f[0] = 32'd5120;
        f[1] = 32'd5632;
        push_frame(f);
        strobe_main(f);
        wait_main("overlap");
        check("overlap_bin20", got[20], 122880);
        check("overlap_bin21", got[21], 122880);
        check("overlap_bin22", got[22], 122880);

        // All formants disabled
        f = '0;
        push_frame(f);
        vcount = 0;
        strobe_main(f);
        wait_main("zero");
        check("zero_valid_count", vcount, 160);
        check("zero_bin80", got[80], 0);
        check("zero_busy_fall", busy_fall - last_last, 1);

        // Back-to-back with an overwritten pending frame
        fa = '0; fa[0] = 32'd7680;
        fb = '0; fb[0] = 32'd17920;
        fc = '0; fc[2] = 32'd30720;
        push_frame(fa);
        push_frame(fc);
        ovr_cnt = 0;
        vcount  = 0;
        strobe_main(fa);
        repeat (98) @(negedge clk);
        strobe_main(fb);
        strobe_main(fc);
        wait_main("b2b");
        check("b2b_gap", b2b_gap, 1);
        check("b2b_overrun_count", ovr_cnt, 1);
        check("b2b_valid_count", vcount, 320);
        check("b2b_bin120", got[120], 65536);

        // Reset in the middle of a frame
        f = '0;
        f[0] = 32'd10240;
        push_frame(f);
        strobe_main(f);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(m_if.spec_valid && m_if.spec_index == 8'd80) && n < 400);
        check("midrst_reach80", n < 400, 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_spec_valid", m_if.spec_valid, 0);
        check("midrst_spec_data", m_if.spec_data, 0);
        check("midrst_spec_index", m_if.spec_index, 0);
        check("midrst_spec_last", m_if.spec_last, 0);
        check("midrst_busy", m_if.busy, 0);
        rst = 1'b0;
        exp_q.delete();
        f = '0;
        f[1] = 32'd2560;
        push_frame(f);
        strobe_main(f);
        wait_main("postrst");
        check("postrst_latency", last_start - sc, 4);
        check("postrst_bin10", got[10], 65536);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
